rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load/memory result).
- Each requester gets a one-entry buffer with a valid/ready handshake.
- Buffered writes are arbitrated round-robin onto a registered write port that drives the register file's WriteEnable_3/Address_3/WriteData_3.
- A combinational pending query lets the hazard logic ask whether a register still has a write in flight.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address (2^ADDR_W registers; register 0 is hard-wired zero).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A offers a write.
- a_ready  out  1  requester A buffer can accept.
- a_addr  in  ADDR_W  requester A destination register.
- a_data  in  DATA_W  requester A write data.
- b_valid, b_ready, b_addr, b_data  as A, for requester B.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- q_addr  in  ADDR_W  pending-query address.
- q_pending  out  1  a write to q_addr is buffered or on the port.

Behaviour:
- Reset (async, rst_n low):
  - buf_a_valid=0, buf_b_valid=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - last_grant=B, so A wins the first contention.
  - Handshakes are ignored while rst_n is low.
- Readiness:
  - x_ready = !buf_x_valid OR grant_x (same-cycle drain and refill allowed). Combinational.
  - Does not depend on x_valid.
- Acceptance:
  - On a rising edge with x_valid & x_ready and x_addr != 0: buf_x captures addr/data and buf_x_valid=1.
  - With x_addr == 0: the handshake completes, nothing is buffered, and no write is ever issued for it.
  - If accepted while grant_x, the buffer is refilled with the new entry (buf_x_valid stays 1).
- Arbitration (combinational, each cycle):
  - Only buf_a_valid: grant_a.
  - Only buf_b_valid: grant_b.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
  - last_grant updates only on a grant.
- Output stage (registered):
  - On a grant: wr_en<=1, wr_addr/wr_data <= granted buffer, and the granted buffer is cleared unless refilled.
  - With no grant: wr_en<=0, and wr_addr/wr_data hold their previous values.
- Latency:
  - Handshake at edge N → wr_en high during cycle after edge N+1 → register file writes at edge N+2.
  - Under contention the loser waits exactly one extra cycle.
  - Max wait for any buffered entry is 1 cycle beyond the minimum.
- Throughput: one write per cycle sustained. With both requesters streaming, A/B alternate and each sees ready every other cycle.
- Ordering:
  - Per-requester order is preserved.
  - Between A and B, order follows grant order only; same-address writes from both sources are ordered by arbitration. Upstream must not depend on any other cross-source ordering.
- q_pending:
  - Combinational.
  - = (q_addr != 0) & ((buf_a_valid & buf_a_addr==q_addr) | (buf_b_valid & buf_b_addr==q_addr) | (wr_en & wr_addr==q_addr)).
  - q_addr=0 always returns 0.
- Mid-operation reset: buffered and in-flight writes are discarded, and wr_en drops immediately (asynchronously).

Test Plan:
- Reset release, idle → a_ready=b_ready=1, wr_en=0, wr_addr=0, wr_data=0, q_pending=0 for all q_addr.
- A offers addr=5, data=0xDEADBEEF for one cycle → wr_en=1, wr_addr=5, wr_data=0xDEADBEEF exactly one cycle after the following edge; q_pending(5)=1 from accept until wr_en falls.
- A (addr=3, 0x11) and B (addr=4, 0x22) accepted at the same edge after reset → writes issue in order addr 3 then addr 4 on consecutive cycles. A second simultaneous pair (7, 0x33)/(8, 0x44) → B's 8 first, then A's 7 (round-robin).
- B streams 4 writes (addr 1..4, data 0xA0..0xA3) with b_valid held high, A idle → b_ready stays 1, wr_en high 4 consecutive cycles, data in order.
- A offers addr=0, data=0xFFFFFFFF → handshake completes (a_ready=1), wr_en never asserts, q_pending(0)=0.
- Buffer A holds addr=9 and B holds addr=10; pull rst_n low mid-cycle → wr_en=0 immediately. After release, no write to 9 or 10 ever appears, and q_pending(9)=q_pending(10)=0.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Handshake, register-file write port and pending-query signals of rf_write_arbiter.
// master is the requester/hazard side; slave is the arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] q_addr;
    logic              q_pending;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, q_pending
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_addr,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, q_pending
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-source register-file write arbiter: one-entry buffer per source, round-robin
// grant onto a registered write port, plus a combinational pending-write query.
module rf_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic                clk,
    input logic                rst_n,
    rf_write_arbiter_if.slave  bus
);
    typedef enum logic {GrantA, GrantB} grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              buf_a_valid_q, buf_a_valid_d;
    logic [ADDR_W-1:0] buf_a_addr_q, buf_a_addr_d;
    logic [DATA_W-1:0] buf_a_data_q, buf_a_data_d;
    logic              buf_b_valid_q, buf_b_valid_d;
    logic [ADDR_W-1:0] buf_b_addr_q, buf_b_addr_d;
    logic [DATA_W-1:0] buf_b_data_q, buf_b_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic grant_a, grant_b;
    logic a_ready, b_ready;
    logic accept_a, accept_b;

    // Under contention the source that did not win last time goes first.
    assign grant_a = buf_a_valid_q & (~buf_b_valid_q | (last_grant_q == GrantB));
    assign grant_b = buf_b_valid_q & ~grant_a;

    assign a_ready = ~buf_a_valid_q | grant_a;
    assign b_ready = ~buf_b_valid_q | grant_b;

    // Writes to register 0 complete the handshake but are dropped.
    assign accept_a = bus.a_valid & a_ready & (bus.a_addr != '0);
    assign accept_b = bus.b_valid & b_ready & (bus.b_addr != '0);

    always_comb begin
        buf_a_valid_d = buf_a_valid_q;
        buf_a_addr_d  = buf_a_addr_q;
        buf_a_data_d  = buf_a_data_q;
        buf_b_valid_d = buf_b_valid_q;
        buf_b_addr_d  = buf_b_addr_q;
        buf_b_data_d  = buf_b_data_q;
        wr_en_d       = grant_a | grant_b;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        last_grant_d  = last_grant_q;

        if (grant_a) begin
            buf_a_valid_d = 1'b0;
            wr_addr_d     = buf_a_addr_q;
            wr_data_d     = buf_a_data_q;
            last_grant_d  = GrantA;
        end else if (grant_b) begin
            buf_b_valid_d = 1'b0;
            wr_addr_d     = buf_b_addr_q;
            wr_data_d     = buf_b_data_q;
            last_grant_d  = GrantB;
        end

        // A new accept overrides the drain, giving same-cycle refill.
        if (accept_a) begin
            buf_a_valid_d = 1'b1;
            buf_a_addr_d  = bus.a_addr;
            buf_a_data_d  = bus.a_data;
        end
        if (accept_b) begin
            buf_b_valid_d = 1'b1;
            buf_b_addr_d  = bus.b_addr;
            buf_b_data_d  = bus.b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q  <= GrantB;
            buf_a_valid_q <= 1'b0;
            buf_a_addr_q  <= '0;
            buf_a_data_q  <= '0;
            buf_b_valid_q <= 1'b0;
            buf_b_addr_q  <= '0;
            buf_b_data_q  <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            buf_a_valid_q <= buf_a_valid_d;
            buf_a_addr_q  <= buf_a_addr_d;
            buf_a_data_q  <= buf_a_data_d;
            buf_b_valid_q <= buf_b_valid_d;
            buf_b_addr_q  <= buf_b_addr_d;
            buf_b_data_q  <= buf_b_data_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign bus.a_ready   = a_ready;
    assign bus.b_ready   = b_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.q_pending = (bus.q_addr != '0) &
                           ((buf_a_valid_q & (buf_a_addr_q == bus.q_addr)) |
                            (buf_b_valid_q & (buf_b_addr_q == bus.q_addr)) |
                            (wr_en_q & (wr_addr_q == bus.q_addr)));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, a mid-operation
// reset sequence and randomized traffic against a queue-based reference model.
module tb_rf_write_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rf_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          av;
        logic [4:0]  aa;
        logic [31:0] ad;
        bit          bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic [4:0]  q;
        bit          ear;
        bit          ebr;
        bit          ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        bit          eqp;
    } row_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    row_t tbl[$];

    // Reference model: each source buffer is a queue holding at most one write.
    wr_t         mq_a[$];
    wr_t         mq_b[$];
    bit          m_last_b;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input bit av, input logic [4:0] aa,
                                input logic [31:0] ad, input bit bv, input logic [4:0] ba,
                                input logic [31:0] bd, input logic [4:0] q, input bit ear,
                                input bit ebr, input bit ewe, input logic [4:0] ewa,
                                input logic [31:0] ewd, input bit eqp);
        row_t r;
        r = '{rst, av, aa, ad, bv, ba, bd, q, ear, ebr, ewe, ewa, ewd, eqp};
        tbl.push_back(r);
    endfunction

    task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic [4:0] q);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        bus.q_addr  = q;
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        chk("reset_wr_en", bus.wr_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic void m_reset();
        mq_a.delete();
        mq_b.delete();
        m_last_b = 1'b1;
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
    endfunction

    function automatic bit m_grant_a();
        return mq_a.size() != 0 && (mq_b.size() == 0 || m_last_b);
    endfunction

    function automatic bit m_grant_b();
        return mq_b.size() != 0 && !m_grant_a();
    endfunction

    function automatic bit m_pending(input logic [4:0] a);
        if (a == 0) return 1'b0;
        foreach (mq_a[i]) if (mq_a[i].addr == a) return 1'b1;
        foreach (mq_b[i]) if (mq_b[i].addr == a) return 1'b1;
        return m_we && m_wa == a;
    endfunction

    function automatic void m_step();
        bit  ga, gb, ra, rb;
        wr_t w;
        ga = m_grant_a();
        gb = m_grant_b();
        ra = mq_a.size() == 0 || ga;
        rb = mq_b.size() == 0 || gb;
        if (ga) begin
            w = mq_a.pop_front();
            m_we = 1'b1; m_wa = w.addr; m_wd = w.data; m_last_b = 1'b0;
        end else if (gb) begin
            w = mq_b.pop_front();
            m_we = 1'b1; m_wa = w.addr; m_wd = w.data; m_last_b = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (bus.a_valid && ra && bus.a_addr != 0) mq_a.push_back('{bus.a_addr, bus.a_data});
        if (bus.b_valid && rb && bus.b_addr != 0) mq_b.push_back('{bus.b_addr, bus.b_data});
    endfunction

    initial begin
        // Single A write, latency and pending window.
        add(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 1, 5, 32'hDEADBEEF, 1);
        add(0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 5, 32'hDEADBEEF, 0);
        // Simultaneous pair after reset: A first.
        add(1, 1, 3, 32'h11, 1, 4, 32'h22, 3, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 1, 3, 32'h11, 1);
        // A-only write leaves A as last grant, so the next pair goes B first.
        add(0, 1, 6, 32'h55, 0, 0, 0, 6, 1, 1, 1, 4, 32'h22, 0);
        add(0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 4, 32'h22, 1);
        add(0, 1, 7, 32'h33, 1, 8, 32'h44, 8, 1, 1, 1, 6, 32'h55, 0);
        add(0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 6, 32'h55, 1);
        add(0, 0, 0, 0, 0, 0, 0, 8, 1, 1, 1, 8, 32'h44, 1);
        add(0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 1, 7, 32'h33, 1);
        add(0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 0, 7, 32'h33, 0);
        // B streams four writes back to back.
        add(0, 0, 0, 0, 1, 1, 32'hA0, 1, 1, 1, 0, 7, 32'h33, 0);
        add(0, 0, 0, 0, 1, 2, 32'hA1, 1, 1, 1, 0, 7, 32'h33, 1);
        add(0, 0, 0, 0, 1, 3, 32'hA2, 2, 1, 1, 1, 1, 32'hA0, 1);
        add(0, 0, 0, 0, 1, 4, 32'hA3, 4, 1, 1, 1, 2, 32'hA1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 1, 3, 32'hA2, 1);
        add(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 1, 4, 32'hA3, 1);
        add(0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 4, 32'hA3, 0);
        // Write to register 0 is accepted and dropped.
        add(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 1, 0, 4, 32'hA3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 32'hA3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 32'hA3, 0);

        // Reset state, with a handshake offered while in reset.
        rst_n = 1'b0;
        drive(1, 5, 32'h1234, 1, 6, 32'h5678, 0);
        #2;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_a_ready", bus.a_ready, 1);
        chk("idle_b_ready", bus.b_ready, 1);
        for (int i = 0; i < 32; i++) begin
            bus.q_addr = 5'(i);
            #0.1;
            chk("idle_q_pending", bus.q_pending, 0);
        end
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, tbl[i].q);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), bus.a_ready, tbl[i].ear);
            chk($sformatf("v%0d_b_ready", i), bus.b_ready, tbl[i].ebr);
            chk($sformatf("v%0d_wr_en", i), bus.wr_en, tbl[i].ewe);
            chk($sformatf("v%0d_wr_addr", i), bus.wr_addr, tbl[i].ewa);
            chk($sformatf("v%0d_wr_data", i), bus.wr_data, tbl[i].ewd);
            chk($sformatf("v%0d_q_pending", i), bus.q_pending, tbl[i].eqp);
            @(posedge clk);
            #1;
        end

        // Mid-operation reset: 9 on the port, 10 still buffered in B.
        do_reset();
        drive(1, 9, 32'h99, 1, 10, 32'h1010, 9);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 10);
        @(posedge clk);
        #1;
        chk("midrst_pre_wr_en", bus.wr_en, 1);
        chk("midrst_pre_wr_addr", bus.wr_addr, 9);
        chk("midrst_pre_q10", bus.q_pending, 1);
        #1 rst_n = 1'b0;
        #0.5;
        chk("midrst_wr_en_drop", bus.wr_en, 0);
        chk("midrst_q10", bus.q_pending, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.q_addr = 5'd9;
            @(negedge clk);
            chk("midrst_after_wr_en", bus.wr_en, 0);
            chk("midrst_after_q9", bus.q_pending, 0);
            bus.q_addr = 5'd10;
            #1;
            chk("midrst_after_q10", bus.q_pending, 0);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
                m_reset();
            end
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
            @(negedge clk);
            chk("rnd_a_ready", bus.a_ready, m_grant_a() || mq_a.size() == 0);
            chk("rnd_b_ready", bus.b_ready, m_grant_b() || mq_b.size() == 0);
            chk("rnd_wr_en", bus.wr_en, m_we);
            chk("rnd_wr_addr", bus.wr_addr, m_wa);
            chk("rnd_wr_data", bus.wr_data, m_wd);
            chk("rnd_q_pending", bus.q_pending, m_pending(bus.q_addr));
            m_step();
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
